// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states, lane helpers.
// Pure declarations and combinational functions; no state, no latency.
// Optional macro LSU_BYTE_ENABLE_EN removes the read-modify-write states.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

`ifdef LSU_BYTE_ENABLE_EN
    typedef enum logic [1:0] {IDLE, LOAD} lsu_state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, RMW_RD, RMW_WR} lsu_state_t;
`endif

    // Pull the addressed big-endian lane(s) to the bottom and extend.
    // Shifting left by the offset puts the wanted bytes at the top of the word.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  offset,
                                                 input logic [1:0]  size,
                                                 input logic        is_unsigned);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word << {offset, 3'b000};
        case (size)
            SZ_BYTE: res = {{24{shifted[31] & ~is_unsigned}}, shifted[31:24]};
            SZ_HALF: res = {{16{shifted[31] & ~is_unsigned}}, shifted[31:16]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Overlay right-justified store data onto the addressed lane(s) of old_word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [1:0]  offset,
                                               input logic [1:0]  size);
        logic [31:0] mask;
        logic [31:0] placed;
        case (size)
            SZ_BYTE: begin
                mask   = 32'hFF00_0000 >> {offset, 3'b000};
                placed = {data[7:0], 24'h0} >> {offset, 3'b000};
            end
            SZ_HALF: begin
                mask   = 32'hFFFF_0000 >> {offset, 3'b000};
                placed = {data[15:0], 16'h0} >> {offset, 3'b000};
            end
            default: begin
                mask   = 32'hFFFF_FFFF;
                placed = data;
            end
        endcase
        return (old_word & ~mask) | (placed & mask);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract (loads) and lane merge (sub-word stores) on one memory word.
// Purely combinational, zero latency.
// No flow control; the caller selects which result it consumes.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] data,
    output logic [31:0] extracted,
    output logic [31:0] merged
);

    assign extracted = lane_extract(word, offset, size, is_unsigned);
    assign merged    = lane_merge(word, data, offset, size);

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end for a word-wide big-endian data memory.
// Loads return one cycle after accept; word stores take zero stall; sub-word stores
// read-modify-write over 3 cycles (req_ready low for 2). Macro LSU_BYTE_ENABLE_EN adds mem_be.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_SIZE = 1024,
    parameter int ADDR_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic              MemoryRead,
    output logic              MemoryWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [31:0]       InputData,
`ifdef LSU_BYTE_ENABLE_EN
    output logic [3:0]        mem_be,
`endif
    input  logic [31:0]       OutputData
);

    lsu_state_t        state;
    logic              accept;
    logic              bad_req;
    logic              go_load;
    logic              go_store;
    logic              store_now;
    logic [ADDR_W-1:0] req_word_addr;
    logic [ADDR_W:0]   last_byte;
    logic [1:0]        align_off;
    logic [1:0]        align_size;
    logic [31:0]       align_data;
    logic [31:0]       align_extract;
    logic [31:0]       align_merge;

`ifndef LSU_BYTE_ENABLE_EN
    logic [ADDR_W-3:0] lat_word;
    logic [1:0]        lat_off;
    logic [1:0]        lat_size;
    logic [31:0]       lat_data;
    logic [31:0]       merged_word;
`endif

    assign req_ready     = (state == IDLE);
    assign accept        = req_valid & req_ready;
    assign req_word_addr = {req_addr[ADDR_W-1:2], 2'b00};
    // Extra top bit so addresses near the top of the space cannot wrap past the bound.
    assign last_byte     = {1'b0, req_word_addr} + (ADDR_W+1)'(3);

    // A request with neither read nor write is a silent no-op, never an error.
    assign bad_req = (req_read | req_write) &
                     ((req_size == 2'd3) ||
                      (req_size == SZ_HALF && req_addr[0]) ||
                      (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
                      (req_read && req_write) ||
                      (last_byte >= (ADDR_W+1)'(DM_SIZE)));

    assign go_load  = accept & ~bad_req & req_read;
    assign go_store = accept & ~bad_req & req_write;

`ifdef LSU_BYTE_ENABLE_EN
    assign store_now  = go_store;
    assign align_off  = req_addr[1:0];
    assign align_size = req_size;
    assign align_data = req_wdata;

    assign MemoryRead  = go_load;
    assign MemoryWrite = store_now;
    assign Address     = req_word_addr;

    // Replicate store data across lanes and enable only the addressed ones.
    always_comb begin
        InputData = req_wdata;
        mem_be    = 4'b0000;
        if (store_now) begin
            case (req_size)
                SZ_BYTE: begin
                    InputData = {4{req_wdata[7:0]}};
                    mem_be    = 4'b1000 >> req_addr[1:0];
                end
                SZ_HALF: begin
                    InputData = {2{req_wdata[15:0]}};
                    mem_be    = 4'b1100 >> req_addr[1:0];
                end
                default: mem_be = 4'b1111;
            endcase
        end
    end
`else
    // Sub-word stores go through RMW; only full words write straight from IDLE.
    assign store_now  = go_store & (req_size == SZ_WORD);
    assign align_off  = (state == IDLE) ? req_addr[1:0] : lat_off;
    assign align_size = (state == IDLE) ? req_size : lat_size;
    assign align_data = lat_data;

    // Enables derive from state so a reset mid-RMW drops MemoryWrite immediately.
    assign MemoryRead  = go_load | (state == RMW_RD);
    assign MemoryWrite = store_now | (state == RMW_WR);
    assign Address     = (state == IDLE) ? req_word_addr : {lat_word, 2'b00};
    assign InputData   = (state == RMW_WR) ? merged_word : req_wdata;
`endif

    lsu_align u_align (
        .word        (OutputData),
        .offset      (align_off),
        .size        (align_size),
        .is_unsigned (req_unsigned),
        .data        (align_data),
        .extracted   (align_extract),
        .merged      (align_merge)
    );

    // Request FSM with registered load/error pulses and RMW latches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            load_valid <= 1'b0;
            load_data  <= '0;
            err        <= 1'b0;
            err_addr   <= '0;
`ifndef LSU_BYTE_ENABLE_EN
            lat_word    <= '0;
            lat_off     <= '0;
            lat_size    <= '0;
            lat_data    <= '0;
            merged_word <= '0;
`endif
        end else begin
            load_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && bad_req) begin
                        err      <= 1'b1;
                        err_addr <= req_addr;
                    end else if (go_load) begin
                        load_data  <= align_extract;
                        load_valid <= 1'b1;
                        state      <= LOAD;
`ifndef LSU_BYTE_ENABLE_EN
                    end else if (go_store && !store_now) begin
                        lat_word <= req_addr[ADDR_W-1:2];
                        lat_off  <= req_addr[1:0];
                        lat_size <= req_size;
                        lat_data <= req_wdata;
                        state    <= RMW_RD;
`endif
                    end
                end
                LOAD: state <= IDLE;
`ifndef LSU_BYTE_ENABLE_EN
                RMW_RD: begin
                    merged_word <= align_merge;
                    state       <= RMW_WR;
                end
                RMW_WR: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array reference memory.
// One negedge compare process checks every cycle; directed cases pin literal values.
// Inputs are driven 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_load_store_unit;

    localparam int DM_SIZE = 1024;
    localparam int NWORDS  = DM_SIZE / 4;
`ifdef LSU_BYTE_ENABLE_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, load_valid, err, MemoryRead, MemoryWrite;
    logic [31:0] load_data, err_addr, Address, InputData, OutputData;
    logic [3:0]  mem_be;

    logic [31:0] env_mem [NWORDS];
    logic [7:0]  ref_b [DM_SIZE];
    logic [31:0] wr_tmp;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    load_store_unit #(.DM_SIZE(DM_SIZE), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_read(req_read), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .load_data(load_data), .load_valid(load_valid),
        .err(err), .err_addr(err_addr),
        .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
        .Address(Address), .InputData(InputData),
`ifdef LSU_BYTE_ENABLE_EN
        .mem_be(mem_be),
`endif
        .OutputData(OutputData)
    );

`ifndef LSU_BYTE_ENABLE_EN
    assign mem_be = 4'hF;
`endif

    // Data memory environment: combinational read, lane-enabled write on the rising edge.
    assign OutputData = (Address < DM_SIZE) ? env_mem[Address[9:2]] : 32'h0;

    always @(posedge clock) begin
        if (MemoryWrite && Address < DM_SIZE) begin
            wr_tmp = env_mem[Address[9:2]];
            for (int l = 0; l < 4; l++)
                if (mem_be[3-l]) wr_tmp[31-8*l -: 8] = InputData[31-8*l -: 8];
            env_mem[Address[9:2]] <= wr_tmp;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (big-endian byte array) ----------------
    function automatic logic [31:0] ref_word(input int a);
        return {ref_b[a], ref_b[a+1], ref_b[a+2], ref_b[a+3]};
    endfunction

    function automatic logic [31:0] ref_load(input int a, input int sz, input bit uns);
        logic [31:0] r;
        if (sz == 0) begin
            r = {24'h0, ref_b[a]};
            if (!uns && ref_b[a][7]) r = r | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            r = {16'h0, ref_b[a], ref_b[a+1]};
            if (!uns && ref_b[a][7]) r = r | 32'hFFFF_0000;
        end else begin
            r = ref_word(a);
        end
        return r;
    endfunction

    task automatic apply_store(input int a, input int sz, input logic [31:0] d);
        int n;
        n = 1 << sz;
        for (int i = 0; i < n; i++) ref_b[a+i] = 8'(d >> (8 * (n - 1 - i)));
    endtask

    function automatic bit model_err(input bit r, input bit w, input int sz, input logic [31:0] a);
        longint top;
        if (!(r || w)) return 1'b0;
        if (sz == 3 || (r && w)) return 1'b1;
        if ((a % (1 << sz)) != 0) return 1'b1;
        top = longint'(a & 32'hFFFF_FFFC) + 3;
        return top >= DM_SIZE;
    endfunction

    task automatic set_word(input int a, input logic [31:0] w);
        env_mem[a/4] = w;
        for (int i = 0; i < 4; i++) ref_b[a+i] = 8'(w >> (8 * (3 - i)));
    endtask

    // ---------------- compare process ----------------
    int          busy = 0;
    bit          pend_v = 1'b0;
    int          pend_addr, pend_size;
    logic [31:0] pend_data;
    bit          exp_lv = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_ld = '0, exp_ea = '0, exp_in;
    logic [3:0]  exp_be;

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_ready", req_ready, 1);
            chk("rst_lv", load_valid, 0);
            chk("rst_ld", load_data, 0);
            chk("rst_err", err, 0);
            chk("rst_ea", err_addr, 0);
            chk("rst_mrd", MemoryRead, 0);
            chk("rst_mwr", MemoryWrite, 0);
            busy = 0; pend_v = 0; exp_lv = 0; exp_err = 0; exp_ea = 0;
        end else begin
            chk("load_valid", load_valid, exp_lv);
            if (exp_lv) chk("load_data", load_data, exp_ld);
            chk("err", err, exp_err);
            chk("err_addr", err_addr, exp_ea);
            chk("req_ready", req_ready, busy == 0);
            chk("rd_wr_excl", MemoryRead & MemoryWrite, 0);
            exp_lv = 0;
            exp_err = 0;
            if (busy != 0) begin
                if (pend_v && busy == 2) begin
                    chk("rmw_rd_mrd", MemoryRead, 1);
                    chk("rmw_rd_mwr", MemoryWrite, 0);
                    chk("rmw_rd_addr", Address, pend_addr & ~3);
                end else if (pend_v) begin
                    apply_store(pend_addr, pend_size, pend_data);
                    pend_v = 0;
                    chk("rmw_wr_mwr", MemoryWrite, 1);
                    chk("rmw_wr_mrd", MemoryRead, 0);
                    chk("rmw_wr_addr", Address, pend_addr & ~3);
                    chk("rmw_wr_data", InputData, ref_word(pend_addr & ~3));
                end else begin
                    chk("busy_mrd", MemoryRead, 0);
                    chk("busy_mwr", MemoryWrite, 0);
                end
                busy--;
            end else if (req_valid && model_err(req_read, req_write, req_size, req_addr)) begin
                exp_err = 1;
                exp_ea  = req_addr;
                chk("err_mrd", MemoryRead, 0);
                chk("err_mwr", MemoryWrite, 0);
            end else if (req_valid && req_read) begin
                exp_lv = 1;
                exp_ld = ref_load(req_addr, req_size, req_unsigned);
                busy   = 1;
                chk("ld_mrd", MemoryRead, 1);
                chk("ld_mwr", MemoryWrite, 0);
                chk("ld_addr", Address, req_addr & ~32'h3);
            end else if (req_valid && req_write && (req_size == 2'd2 || BE)) begin
                chk("st_mwr", MemoryWrite, 1);
                chk("st_mrd", MemoryRead, 0);
                chk("st_addr", Address, req_addr & ~32'h3);
`ifdef LSU_BYTE_ENABLE_EN
                exp_in = (req_size == 2'd0) ? {4{req_wdata[7:0]}} :
                         (req_size == 2'd1) ? {2{req_wdata[15:0]}} : req_wdata;
                exp_be = '0;
                for (int l = 0; l < 4; l++)
                    if (l >= int'(req_addr[1:0]) && l < int'(req_addr[1:0]) + (1 << req_size))
                        exp_be[3-l] = 1'b1;
                chk("st_be", mem_be, exp_be);
`else
                exp_in = req_wdata;
`endif
                chk("st_data", InputData, exp_in);
                apply_store(req_addr, req_size, req_wdata);
            end else if (req_valid && req_write) begin
                chk("sub_acc_mrd", MemoryRead, 0);
                chk("sub_acc_mwr", MemoryWrite, 0);
                pend_v = 1; pend_addr = req_addr; pend_size = req_size; pend_data = req_wdata;
                busy = 2;
            end else begin
                chk("idle_mrd", MemoryRead, 0);
                chk("idle_mwr", MemoryWrite, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic resync();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) resync();
    endtask

    // Present a request, wait (bounded) for acceptance, return 1ns after the accepting edge.
    task automatic drive(input bit r, input bit w, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] d);
        int t;
        req_valid = 1; req_read = r; req_write = w; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = d;
        t = 0;
        @(negedge clock);
        while (!req_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("accept_timeout", req_ready, 1);
        resync();
        req_valid = 0;
    endtask

    initial begin
        int kind, sz;
        logic [31:0] a;
        for (int i = 0; i < NWORDS; i++) set_word(i * 4, $urandom);

        #1 reset = 1;
        repeat (3) @(negedge clock);
        resync();
        reset = 0;
        idle(1);

        // Loads with sign/zero extension.
        set_word(32'h10, 32'h80FF7F01);
        drive(1, 0, 2'd0, 0, 32'h10, 0);
        @(negedge clock); chk("lit_lb", load_data, 32'hFFFFFF80); resync();
        drive(1, 0, 2'd0, 1, 32'h11, 0);
        @(negedge clock); chk("lit_lbu", load_data, 32'h000000FF); resync();
        drive(1, 0, 2'd1, 0, 32'h12, 0);
        @(negedge clock); chk("lit_lh", load_data, 32'h00007F01); resync();

        // Sub-word store over a known word.
        set_word(32'h20, 32'h11223344);
        drive(0, 1, 2'd0, 0, 32'h21, 32'h000000AB);
        idle(3);
        chk("lit_sb_mem", env_mem[8], 32'h11AB3344);

        // Word store then back-to-back word load.
        drive(0, 1, 2'd2, 0, 32'h40, 32'hDEADBEEF);
        drive(1, 0, 2'd2, 0, 32'h40, 0);
        @(negedge clock); chk("lit_lw_after_sw", load_data, 32'hDEADBEEF); resync();

        // Error cases.
        drive(1, 0, 2'd2, 0, 32'h42, 0);
        @(negedge clock); chk("lit_err_lw42", err, 1); chk("lit_ea_lw42", err_addr, 32'h42); resync();
        drive(0, 1, 2'd1, 0, 32'h13, 0);
        @(negedge clock); chk("lit_err_sh13", err, 1); chk("lit_ea_sh13", err_addr, 32'h13); resync();
        drive(1, 0, 2'd3, 0, 32'h50, 0);
        @(negedge clock); chk("lit_err_sz3", err, 1); resync();
        drive(1, 1, 2'd2, 0, 32'h54, 0);
        @(negedge clock); chk("lit_err_rw", err, 1); chk("lit_ea_rw", err_addr, 32'h54); resync();
        drive(1, 0, 2'd2, 0, 32'd1024, 0);
        @(negedge clock); chk("lit_err_oob", err, 1); chk("lit_ea_oob", err_addr, 32'd1024); resync();

`ifdef LSU_BYTE_ENABLE_EN
        // Half store with byte enables completes in the accept cycle.
        req_valid = 1; req_read = 0; req_write = 1; req_size = 2'd1;
        req_unsigned = 0; req_addr = 32'h22; req_wdata = 32'h0000BEEF;
        @(negedge clock);
        chk("lit_be_mask", mem_be, 4'b0011);
        chk("lit_be_data", InputData, 32'hBEEFBEEF);
        resync();
        req_valid = 0;
`else
        // Reset during the RMW read cycle abandons the write.
        set_word(32'h80, 32'hCAFEF00D);
        drive(0, 1, 2'd0, 0, 32'h81, 32'h00000055);
        reset = 1;
        @(negedge clock); chk("lit_rst_mwr", MemoryWrite, 0); chk("lit_rst_ready", req_ready, 1);
        resync();
        reset = 0;
        idle(2);
        chk("lit_rst_mem", env_mem[32], 32'hCAFEF00D);
        drive(1, 0, 2'd2, 0, 32'h80, 0);
        @(negedge clock); chk("lit_rst_lw", load_data, 32'hCAFEF00D); resync();
`endif

        // Randomized traffic.
        repeat (1500) begin
            kind = $urandom_range(0, 99);
            sz   = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
            a    = ($urandom_range(0, 49) == 0) ? $urandom : 32'($urandom_range(0, DM_SIZE + 7));
            if (sz < 3 && $urandom_range(0, 7) != 0) a = a & ~32'((1 << sz) - 1);
            drive(kind < 45 || (kind >= 90 && kind < 95), kind >= 45 && kind < 95,
                  2'(sz), 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(4);

        for (int i = 0; i < NWORDS; i++) chk("mem_final", env_mem[i], ref_word(i * 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
